// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - parametrised multi-read register file with clear sweep and busy scoreboard
// Optional write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_multiport #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  set_busy,
  input  logic [AW-1:0]         busy_addr
);

  typedef enum logic {CLR, RDY} state_t;

  state_t            state;
  logic [AW-1:0]     cnt;
  logic [XLEN-1:0]   mem [NREG];
  logic [NREG-1:0]   busy;

  logic              wr_ok;
  logic              sb_ok;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [XLEN-1:0]   mem_data;

  assign ready = (state == RDY);
  assign wr_ok = ready && we && (waddr != '0);
  assign sb_ok = ready && set_busy && (busy_addr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLR;
      cnt   <= AW'(1);
    end else if (state == CLR) begin
      cnt <= cnt + AW'(1);
      if (cnt == AW'(NREG - 1)) state <= RDY;
    end
  end

  // Single write port shared by the clear sweep and normal writeback, so the
  // array maps onto a plain RAM without a per-entry reset.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = waddr;
    mem_data = wdata;
    if (!rst) begin
      if (state == CLR) begin
        mem_we   = 1'b1;
        mem_addr = cnt;
        mem_data = '0;
      end else if (wr_ok) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
  end

  // A set in the same cycle as the write overrides the clear: a new producer issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wr_ok) busy[waddr] <= 1'b0;
      if (sb_ok) busy[busy_addr] <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < NREAD; k++) begin
      logic [AW-1:0] ra;
      logic          byp;
      ra  = raddr[k*AW +: AW];
      byp = 1'b0;
`ifdef REGFILE_BYPASS_EN
      byp = wr_ok && (waddr == ra);
`endif
      if (ready && (ra != '0)) begin
        rdata[k*XLEN +: XLEN] = byp ? wdata : mem[ra];
        rbusy[k]              = busy[ra] && !(byp && !(sb_ok && (busy_addr == ra)));
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - directed self-checking bench for regfile_multiport
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        set_busy;
  logic [4:0]  busy_addr;

  int checks = 0;
  int errors = 0;

  regfile_multiport dut (
    .clk(clk), .rst(rst), .ready(ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .set_busy(set_busy), .busy_addr(busy_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  int n;
  logic [31:0] exp_byp;
  logic [31:0] exp_bsy;

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    set_busy = 1'b0; busy_addr = '0;
    tick();
    check("reset_ready", {31'b0, ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("sweep_ready_low", {31'b0, ready}, 32'd0);
    // write attempted for the whole sweep must be dropped
    we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF_FFFF;
    wait_ready(n);
    we = 1'b0;
    check("sweep_len", n, 32'd31);

    for (int r = 0; r < 32; r++) begin
      raddr = {5'(31 - r), 5'(r)};
      #1;
      check("clr_rd0", rdata[31:0], 32'd0);
      check("clr_rd1", rdata[63:32], 32'd0);
      check("clr_busy", {30'b0, rbusy}, 32'd0);
    end

    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    tick();
    we = 1'b0; raddr = {5'd5, 5'd5};
    #1;
    check("x5_p0", rdata[31:0], 32'hDEAD_BEEF);
    check("x5_p1", rdata[63:32], 32'hDEAD_BEEF);

    we = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678;
    tick();
    we = 1'b0; raddr = {5'd0, 5'd0};
    #1;
    check("x0_zero", rdata[31:0], 32'd0);

`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'hA5A5_A5A5;
`else
    exp_byp = 32'd0;
`endif
    raddr = {5'd3, 5'd7};
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5;
    #1;
    check("bypass_same", rdata[31:0], exp_byp);
    check("x3_dropped", rdata[63:32], 32'd0);
    tick();
    we = 1'b0;
    #1;
    check("x7_next", rdata[31:0], 32'hA5A5_A5A5);

    raddr = {5'd0, 5'd9};
    set_busy = 1'b1; busy_addr = 5'd9;
    #1;
    check("busy_pre", {30'b0, rbusy}, 32'd0);
    tick();
    set_busy = 1'b0;
    #1;
    check("busy_set", {30'b0, rbusy}, 32'd1);

    we = 1'b1; waddr = 5'd9; wdata = 32'd1; set_busy = 1'b1; busy_addr = 5'd9;
    #1;
    check("busy_wr_set_now", {30'b0, rbusy}, 32'd1);
    tick();
    we = 1'b0; set_busy = 1'b0;
    #1;
    check("busy_set_wins", {30'b0, rbusy}, 32'd1);
    check("x9_val1", rdata[31:0], 32'd1);

`ifdef REGFILE_BYPASS_EN
    exp_bsy = 32'd0;
`else
    exp_bsy = 32'd1;
`endif
    we = 1'b1; waddr = 5'd9; wdata = 32'd2;
    #1;
    check("busy_wr_now", {30'b0, rbusy}, exp_bsy);
    tick();
    we = 1'b0;
    #1;
    check("busy_cleared", {30'b0, rbusy}, 32'd0);
    check("x9_val2", rdata[31:0], 32'd2);

    // write and set to different registers in the same cycle
    we = 1'b1; waddr = 5'd11; wdata = 32'd3; set_busy = 1'b1; busy_addr = 5'd12;
    tick();
    we = 1'b0; set_busy = 1'b0; raddr = {5'd12, 5'd11};
    #1;
    check("diff_wr", rdata[31:0], 32'd3);
    check("diff_busy", {30'b0, rbusy}, 32'd2);

    set_busy = 1'b1; busy_addr = 5'd0;
    tick();
    busy_addr = 5'd9;
    tick();
    set_busy = 1'b0; raddr = {5'd9, 5'd0};
    #1;
    check("x0_busy", {31'b0, rbusy[0]}, 32'd0);
    check("x9_busy_again", {31'b0, rbusy[1]}, 32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_ready", {31'b0, ready}, 32'd0);
    check("rst_mid_busy_hidden", {30'b0, rbusy}, 32'd0);
    wait_ready(n);
    check("rst_mid_len", n, 32'd31);
    raddr = {5'd9, 5'd5};
    #1;
    check("rst_x5", rdata[31:0], 32'd0);
    check("rst_x9_busy", {31'b0, rbusy[1]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
Name:
regfile_multiport

Overview:
- Parametrised successor to the core's single-write, dual-read integer register file.
- Width, register count and read-port count are generic.
- Adds a RAM-friendly sequential clear sweep after reset in place of a parallel flop reset.
- Adds a per-register busy scoreboard for pending writebacks and an optional write-to-read bypass.
- Sits between decode (reads, busy queries) and writeback (writes) in the RISC-V datapath.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers; power of two, at least 4.
- NREAD, 2, number of independent read ports.
- AW, $clog2(NREG), address width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ready  output  1  high when the clear sweep is done and the file accepts writes.
- we  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  XLEN  write data.
- raddr  input  NREAD*AW  read addresses; port k uses bits [k*AW +: AW].
- rdata  output  NREAD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]. Combinational.
- rbusy  output  NREAD  busy bit of the register addressed by port k. Combinational.
- set_busy  input  1  marks register busy_addr as pending.
- busy_addr  input  AW  register to mark busy.

Behaviour:
- Storage:
  - NREG x XLEN array with no per-entry reset.
  - Entry 0 is never written and always reads 0.
- Clear FSM, two states: CLR and RDY.
  - rst high at an edge: state becomes CLR, clear counter cnt becomes 1, all busy bits clear, ready becomes 0.
  - CLR with rst low: mem[cnt] is written 0 and cnt increments. On the edge that clears entry NREG-1, state becomes RDY.
  - ready is high exactly NREG-1 edges after the first edge with rst low.
  - rst held high keeps cnt at 1.
  - rst asserted while in RDY, or mid-sweep, restarts the sweep from 1.
  - ready is driven from the state register; its reset value is 0.
- Writes:
  - Take effect at the edge only when ready=1, we=1 and waddr!=0.
  - Writes in CLR are dropped silently; they are not queued.
- Reads:
  - rdata[k] is 0 if ready=0 or raddr[k]==0.
  - Otherwise it follows the bypass rule (see Optional Feature), else mem[raddr[k]].
- Busy scoreboard:
  - One bit per register. Bit 0 is hard-wired to 0.
  - A write to register r (accepted per the rules above) clears busy[r].
  - set_busy with busy_addr=r sets busy[r]. It is ignored when ready=0 or r==0.
  - set_busy and a write to the same r in the same cycle: set wins, so busy[r]=1 (a new producer has issued).
  - set_busy and a write to different registers in the same cycle are both applied.
  - rbusy[k] = busy[raddr[k]], and is 0 when ready=0.
- All read ports are fully independent; the same address on several ports is legal.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If ready=1, we=1, waddr!=0 and waddr==raddr[k], then rdata[k]=wdata in the same cycle.
  - rbusy[k] is forced to 0 for that port that cycle, unless set_busy targets the same register.
- Undefined:
  - Reads return the stored value; a same-cycle write is visible from the next cycle.
  - rbusy reflects the registered bit only.

Test Plan:
- Reset sweep, NREG=32:
  - rst high for 2 cycles, then low -> ready=0 for 31 cycles, then 1.
  - All 32 registers then read 0, and all rbusy=0.
- Basic write/read:
  - After ready, write x5=0xDEADBEEF, read x5 on port 0 and x5 on port 1 next cycle -> both ports 0xDEADBEEF.
- x0 and bypass:
  - Write x0=0x12345678 -> reads 0.
  - Write x7=0xA5A5A5A5 with raddr0=7 in the same cycle -> rdata0=0xA5A5A5A5 with REGFILE_BYPASS_EN, previous value 0 without it.
- Scoreboard:
  - set_busy x9 -> rbusy=1 next cycle.
  - Write x9 together with set_busy x9 -> rbusy stays 1.
  - Write x9 alone -> rbusy=0 next cycle.
- Write during sweep:
  - Write x3=0xFFFFFFFF while ready=0 -> after ready, x3 reads 0.
- Reset mid-operation:
  - With x5=0xDEADBEEF and x9 busy, pulse rst for 1 cycle -> ready low for 31 cycles.
  - Afterwards x5 reads 0 and rbusy for x9 is 0.
